// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch front end.
// Holds the NOP encoding, the register-field bit positions used by decode and
// the hazard unit, the PC width and step, and the per-edge action type with
// the helper that resolves Flush/Stall priority.
package if_id_stage_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2
  } pipe_action_e;

  // Flush wins over Stall so a taken branch is never dropped while the
  // hazard unit happens to be holding the pipe.
  function automatic pipe_action_e resolve_action(input logic flush, input logic stall);
    if (flush) begin
      return ACT_FLUSH;
    end else if (stall) begin
      return ACT_STALL;
    end
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/if_id_stage_pc_unit.sv
// pc_unit: program counter register with its +4 adder and redirect/hold mux.
// Ports:
//   Clk, Rst        clock and asynchronous active-high reset
//   Stall, Flush    hold request and branch redirect request
//   Branch_Target   redirect address, word-aligned internally
//   pc              current fetch address
//   pc_plus4        pc + 4 (wraps modulo 2^32), also used for PC4_ID
module pc_unit
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic [PC_W-1:0] Branch_Target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  pipe_action_e action;

  assign action   = resolve_action(Flush, Stall);
  assign pc_plus4 = pc + PC_STEP;

  // Branch targets are forced to word alignment; the adder simply wraps
  // from FFFF_FFFC back to zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc <= RESET_PC;
    end else begin
      unique case (action)
        ACT_FLUSH:   pc <= {Branch_Target[PC_W-1:2], 2'b00};
        ACT_STALL:   pc <= pc;
        ACT_ADVANCE: pc <= pc_plus4;
        default:     pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch-side front end, PC register plus IF/ID pipeline register.
// Ports:
//   Clk, Rst        clock and asynchronous active-high reset
//   Stall           hold PC and IF/ID (registered by the hazard unit already)
//   Flush           taken branch: redirect PC to Branch_Target, squash IF/ID
//   Branch_Target   redirect address
//   Instr_IF        instruction memory data for PC_IF
//   PC_IF           fetch address
//   Instr_ID        registered instruction, PC4_ID its PC+4, Valid_ID 0 = bubble
//   Rs_ID, Rt_ID    register fields of Instr_ID for the hazard unit
//   Stall_Count     saturating count of all stalled cycles since reset
//   Stall_Timeout   sticky flag: Stall held more than MAX_STALL cycles in a row
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [31:0]      Branch_Target,
  input  logic [31:0]      Instr_IF,
  output logic [31:0]      PC_IF,
  output logic [31:0]      Instr_ID,
  output logic [31:0]      PC4_ID,
  output logic             Valid_ID,
  output logic [4:0]       Rs_ID,
  output logic [4:0]       Rt_ID,
  output logic [CNT_W-1:0] Stall_Count,
  output logic             Stall_Timeout
);

  // Wide enough to hold MAX_STALL+1, so "would exceed" is always reachable
  // before the counter saturates.
  localparam int CONS_W = $clog2(MAX_STALL + 2);
  localparam logic [CONS_W-1:0] MAX_STALL_C = CONS_W'(MAX_STALL);

  pipe_action_e      action;
  logic [31:0]       pc_plus4;
  logic [CONS_W-1:0] consec_count;
  logic [CONS_W-1:0] consec_next;

  assign action = resolve_action(Flush, Stall);

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .Clk           (Clk),
    .Rst           (Rst),
    .Stall         (Stall),
    .Flush         (Flush),
    .Branch_Target (Branch_Target),
    .pc            (PC_IF),
    .pc_plus4      (pc_plus4)
  );

  assign Rs_ID = Instr_ID[RS_MSB:RS_LSB];
  assign Rt_ID = Instr_ID[RT_MSB:RT_LSB];

  // Saturating increment of the consecutive-stall run length.
  assign consec_next = (consec_count == '1) ? consec_count : consec_count + CONS_W'(1);

  // IF/ID register: a flush inserts a bubble, a stall holds, otherwise the
  // fetched word moves into decode together with its PC+4.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Instr_ID <= NOP;
      PC4_ID   <= '0;
      Valid_ID <= 1'b0;
    end else begin
      unique case (action)
        ACT_FLUSH: begin
          Instr_ID <= NOP;
          PC4_ID   <= '0;
          Valid_ID <= 1'b0;
        end
        ACT_STALL: begin
          Instr_ID <= Instr_ID;
          PC4_ID   <= PC4_ID;
          Valid_ID <= Valid_ID;
        end
        default: begin
          Instr_ID <= Instr_IF;
          PC4_ID   <= pc_plus4;
          Valid_ID <= 1'b1;
        end
      endcase
    end
  end

  // Stall statistics and watchdog. Only a genuine hold counts; a stall
  // overridden by a flush neither counts nor extends the current run.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Stall_Count   <= '0;
      consec_count  <= '0;
      Stall_Timeout <= 1'b0;
    end else begin
      if (action == ACT_STALL) begin
        if (Stall_Count != '1) begin
          Stall_Count <= Stall_Count + CNT_W'(1);
        end
        consec_count <= consec_next;
        if (consec_next > MAX_STALL_C) begin
          Stall_Timeout <= 1'b1;
        end
      end else begin
        consec_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage: reset, free-run fetch, stall hold,
// flush-over-stall, PC wrap, stall watchdog boundary and asynchronous reset.
module tb_if_id_stage;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic [31:0] Branch_Target;
  logic [31:0] Instr_IF;
  logic [31:0] PC_IF;
  logic [31:0] Instr_ID;
  logic [31:0] PC4_ID;
  logic        Valid_ID;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic [15:0] Stall_Count;
  logic        Stall_Timeout;

  int checks = 0;
  int errors = 0;

  if_id_stage #(
    .RESET_PC  (32'h0000_0000),
    .CNT_W     (16),
    .MAX_STALL (8)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Stall         (Stall),
    .Flush         (Flush),
    .Branch_Target (Branch_Target),
    .Instr_IF      (Instr_IF),
    .PC_IF         (PC_IF),
    .Instr_ID      (Instr_ID),
    .PC4_ID        (PC4_ID),
    .Valid_ID      (Valid_ID),
    .Rs_ID         (Rs_ID),
    .Rt_ID         (Rt_ID),
    .Stall_Count   (Stall_Count),
    .Stall_Timeout (Stall_Timeout)
  );

  // Free-running 10-time-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Drive one cycle of inputs, then sample 1 unit after the rising edge.
  task automatic applyStimulus(input logic stall, input logic flush,
                               input logic [31:0] target, input logic [31:0] instr);
    Stall         = stall;
    Flush         = flush;
    Branch_Target = target;
    Instr_IF      = instr;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    Rst           = 1'b1;
    Stall         = 1'b0;
    Flush         = 1'b0;
    Branch_Target = 32'h0;
    Instr_IF      = 32'h8C22_0004;

    // Reset values, before any clock edge.
    #1;
    checkOutput("rst_pc",      PC_IF,                32'h0);
    checkOutput("rst_instr",   Instr_ID,             32'h0);
    checkOutput("rst_pc4",     PC4_ID,               32'h0);
    checkOutput("rst_valid",   {31'b0, Valid_ID},    32'h0);
    checkOutput("rst_scount",  {16'b0, Stall_Count}, 32'h0);
    checkOutput("rst_timeout", {31'b0, Stall_Timeout}, 32'h0);

    @(negedge Clk);
    Rst = 1'b0;

    // Free-running fetch of a lw instruction (rs=1, rt=2).
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h8C22_0004);
    checkOutput("run1_pc",    PC_IF,             32'h4);
    checkOutput("run1_instr", Instr_ID,          32'h8C22_0004);
    checkOutput("run1_valid", {31'b0, Valid_ID}, 32'h1);
    checkOutput("run1_pc4",   PC4_ID,            32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h8C22_0004);
    checkOutput("run2_pc",    PC_IF,             32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h8C22_0004);
    checkOutput("run3_pc",    PC_IF,             32'hC);
    checkOutput("run3_pc4",   PC4_ID,            32'hC);
    checkOutput("run3_rs",    {27'b0, Rs_ID},    32'h1);
    checkOutput("run3_rt",    {27'b0, Rt_ID},    32'h2);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h8C22_0004);
    checkOutput("run4_pc",    PC_IF,             32'h10);

    // Two stall cycles at PC 0x10; garbage on Instr_IF must be ignored.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    checkOutput("stall_pc",     PC_IF,                32'h10);
    checkOutput("stall_instr",  Instr_ID,             32'h8C22_0004);
    checkOutput("stall_valid",  {31'b0, Valid_ID},    32'h1);
    checkOutput("stall_pc4",    PC4_ID,               32'h10);
    checkOutput("stall_scount", {16'b0, Stall_Count}, 32'h2);

    // Release: add r2,r5,r5 enters decode (rs=5, rt=5).
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h00A5_1020);
    checkOutput("rel_pc",    PC_IF,          32'h14);
    checkOutput("rel_instr", Instr_ID,       32'h00A5_1020);
    checkOutput("rel_pc4",   PC4_ID,         32'h14);
    checkOutput("rel_rs",    {27'b0, Rs_ID}, 32'h5);

    // Flush and Stall together: branch wins, target aligned, count unchanged.
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 32'h1234_5678);
    checkOutput("flush_pc",     PC_IF,                32'h100);
    checkOutput("flush_instr",  Instr_ID,             32'h0);
    checkOutput("flush_valid",  {31'b0, Valid_ID},    32'h0);
    checkOutput("flush_pc4",    PC4_ID,               32'h0);
    checkOutput("flush_scount", {16'b0, Stall_Count}, 32'h2);

    // PC wrap from FFFF_FFFC.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    checkOutput("wrap_setup_pc", PC_IF, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0221_8020);
    checkOutput("wrap_pc",    PC_IF,             32'h0);
    checkOutput("wrap_pc4",   PC4_ID,            32'h0);
    checkOutput("wrap_valid", {31'b0, Valid_ID}, 32'h1);

    // Exactly MAX_STALL consecutive stalls: no timeout.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    end
    checkOutput("s8_timeout", {31'b0, Stall_Timeout}, 32'h0);
    checkOutput("s8_scount",  {16'b0, Stall_Count},   32'd10);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("s8_rel_timeout", {31'b0, Stall_Timeout}, 32'h0);

    // MAX_STALL+1 consecutive stalls: timeout after the 9th edge, sticky.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    end
    checkOutput("s9_pre_timeout", {31'b0, Stall_Timeout}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("s9_timeout", {31'b0, Stall_Timeout}, 32'h1);
    checkOutput("s9_scount",  {16'b0, Stall_Count},   32'd19);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("s9_sticky",  {31'b0, Stall_Timeout}, 32'h1);

    // Asynchronous reset pulsed between edges while stalled.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    #2;
    Rst = 1'b1;
    #1;
    checkOutput("arst_pc",      PC_IF,                  32'h0);
    checkOutput("arst_instr",   Instr_ID,               32'h0);
    checkOutput("arst_valid",   {31'b0, Valid_ID},      32'h0);
    checkOutput("arst_scount",  {16'b0, Stall_Count},   32'h0);
    checkOutput("arst_timeout", {31'b0, Stall_Timeout}, 32'h0);
    #1;
    Rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h8C22_0004);
    checkOutput("post_rst_pc", PC_IF, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
